// File: rtl/alu_pkg.sv
// Shared opcode and scheduler state encodings for the ALU scheduler slice.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_NOT = 3'd2,
      OP_AND = 3'd3,
      OP_OR  = 3'd4,
      OP_XOR = 3'd5,
      OP_CMP = 3'd6,
      OP_EQU = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int OP_W = 3;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU with carry/zero/overflow flags; zero latency, no flow control.
module alu
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  alu_op_e        sel,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [N-1:0]   s,
   output logic           carry,
   output logic           zero,
   output logic           overflow
);

   logic [N:0] add_r;
   logic [N:0] sub_r;
   logic       add_ov;
   logic       sub_ov;
   logic       lt;

   assign add_r  = {1'b0, a} + {1'b0, b};
   assign sub_r  = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
   assign add_ov = (a[N-1] == b[N-1]) && (add_r[N-1] != a[N-1]);
   assign sub_ov = (a[N-1] != b[N-1]) && (sub_r[N-1] != a[N-1]);
   // Signed less-than: sign of the difference corrected by overflow.
   assign lt     = sub_r[N-1] ^ sub_ov;

   always_comb begin
      s        = '0;
      carry    = 1'b0;
      zero     = 1'b0;
      overflow = 1'b0;
      case (sel)
         OP_ADD: begin
            s        = add_r[N-1:0];
            carry    = add_r[N];
            zero     = ~|add_r[N-1:0];
            overflow = add_ov;
         end
         OP_SUB, OP_CMP, OP_EQU: begin
            carry    = sub_r[N];
            zero     = ~|sub_r[N-1:0];
            overflow = sub_ov;
            if (sel == OP_SUB)
               s = sub_r[N-1:0];
            else if (sel == OP_CMP)
               s = {N{lt}};
            else
               s = {N{a == b}};
         end
         OP_NOT:  s = ~a;
         OP_AND:  s = a & b;
         OP_OR:   s = a | b;
         OP_XOR:  s = a ^ b;
         default: s = '0;
      endcase
   end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler feeding one shared ALU; grant -> result valid two cycles later.
// One op in flight; requesters see req_ready low until the result is consumed via rsp_ready.
module alu_sched
   import alu_pkg::*;
#(
   parameter int N  = 4,
   parameter int R  = 4,
   parameter int IW = $clog2(R)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [R-1:0]    req_valid,
   output logic [R-1:0]    req_ready,
   input  logic [3*R-1:0]  req_sel,
   input  logic [N*R-1:0]  req_a,
   input  logic [N*R-1:0]  req_b,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [IW-1:0]   rsp_id,
   output logic [N-1:0]    rsp_s,
   output logic            rsp_carry,
   output logic            rsp_zero,
   output logic            rsp_overflow,
   output logic            busy
);

   state_e             state;
   state_e             state_nxt;
   logic [IW-1:0]      ptr;
   alu_op_e            op_sel;
   logic [N-1:0]       op_a;
   logic [N-1:0]       op_b;
   logic [IW-1:0]      op_id;

   logic               gnt_found;
   logic [IW-1:0]      gnt_id;
   logic [OP_W-1:0]    gnt_sel;
   logic [N-1:0]       gnt_a;
   logic [N-1:0]       gnt_b;
   logic               hs;

   logic [N-1:0]       alu_s;
   logic               alu_carry;
   logic               alu_zero;
   logic               alu_overflow;

   // Search from ptr upward with wrap; the first valid requester wins.
   always_comb begin
      logic [IW:0]   sum;
      logic [IW-1:0] idx;
      gnt_found = 1'b0;
      gnt_id    = '0;
      sum       = '0;
      idx       = '0;
      for (int i = 0; i < R; i++) begin
         sum = {1'b0, ptr} + (IW+1)'(i);
         if (sum >= (IW+1)'(R))
            sum = sum - (IW+1)'(R);
         idx = sum[IW-1:0];
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = idx;
         end
      end
   end

   always_comb begin
      gnt_sel = '0;
      gnt_a   = '0;
      gnt_b   = '0;
      for (int i = 0; i < R; i++) begin
         if (IW'(i) == gnt_id) begin
            gnt_sel = req_sel[3*i +: 3];
            gnt_a   = req_a[N*i +: N];
            gnt_b   = req_b[N*i +: N];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      hs        = 1'b0;
      req_ready = '0;
      case (state)
         ST_IDLE: begin
            if (gnt_found) begin
               hs        = 1'b1;
               req_ready = {{(R-1){1'b0}}, 1'b1} << gnt_id;
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: state_nxt = ST_RESP;
         ST_RESP: begin
            if (rsp_ready)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign rsp_valid = (state == ST_RESP);
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         ptr          <= '0;
         op_sel       <= OP_ADD;
         op_a         <= '0;
         op_b         <= '0;
         op_id        <= '0;
         rsp_s        <= '0;
         rsp_carry    <= 1'b0;
         rsp_zero     <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_id       <= '0;
      end else begin
         state <= state_nxt;
         if (hs) begin
            op_sel <= alu_op_e'(gnt_sel);
            op_a   <= gnt_a;
            op_b   <= gnt_b;
            op_id  <= gnt_id;
            ptr    <= (gnt_id == IW'(R-1)) ? '0 : gnt_id + IW'(1);
         end
         if (state == ST_EXEC) begin
            rsp_s        <= alu_s;
            rsp_carry    <= alu_carry;
            rsp_zero     <= alu_zero;
            rsp_overflow <= alu_overflow;
            rsp_id       <= op_id;
         end
      end
   end

   alu #(.N(N)) u_alu (
      .sel      (op_sel),
      .a        (op_a),
      .b        (op_b),
      .s        (alu_s),
      .carry    (alu_carry),
      .zero     (alu_zero),
      .overflow (alu_overflow)
   );

endmodule

// File: tb/tb_alu_sched.sv
// Randomized and directed bench for alu_sched against a transaction-level reference model.
module tb_alu_sched;

   localparam int N  = 4;
   localparam int R  = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [R-1:0]    req_valid = '0;
   logic [R-1:0]    req_ready;
   logic [3*R-1:0]  req_sel = '0;
   logic [N*R-1:0]  req_a = '0;
   logic [N*R-1:0]  req_b = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [IW-1:0]   rsp_id;
   logic [N-1:0]    rsp_s;
   logic            rsp_carry;
   logic            rsp_zero;
   logic            rsp_overflow;
   logic            busy;

   typedef struct {
      int id;
      int s;
      int c;
      int z;
      int v;
   } rsp_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_ptr   = 0;
   int   m_stage = 0;   // 0 free, 1 computing, 2 presenting result
   rsp_t m_exp;
   rsp_t got[$];
   int   last_rdy;

   alu_sched #(.N(N), .R(R), .IW(IW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_sel      (req_sel),
      .req_a        (req_a),
      .req_b        (req_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_s        (rsp_s),
      .rsp_carry    (rsp_carry),
      .rsp_zero     (rsp_zero),
      .rsp_overflow (rsp_overflow),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sgn(input int x);
      return (x >= (1 << (N-1))) ? x - (1 << N) : x;
   endfunction

   function automatic rsp_t ref_alu(input int op, input int a, input int b, input int id);
      rsp_t r;
      int mask  = (1 << N) - 1;
      int t_add = a + b;
      int t_sub = a + ((~b) & mask) + 1;
      int d_add = sgn(a) + sgn(b);
      int d_sub = sgn(a) - sgn(b);
      int lo    = -(1 << (N-1));
      int hi    = (1 << (N-1)) - 1;
      r.id = id; r.s = 0; r.c = 0; r.z = 0; r.v = 0;
      case (op)
         0:       begin r.s = t_add & mask; r.c = (t_add >> N) & 1; r.v = int'(d_add < lo || d_add > hi); end
         1, 6, 7: begin r.s = t_sub & mask; r.c = (t_sub >> N) & 1; r.v = int'(d_sub < lo || d_sub > hi); end
         2:       r.s = (~a) & mask;
         3:       r.s = a & b;
         4:       r.s = a | b;
         5:       r.s = a ^ b;
         default: r.s = 0;
      endcase
      if (op <= 1 || op >= 6) r.z = int'(r.s == 0);
      if (op == 6) r.s = (sgn(a) < sgn(b)) ? mask : 0;
      if (op == 7) r.s = (a == b) ? mask : 0;
      return r;
   endfunction

   // One clock: drive inputs after the falling edge, check, then advance the model to the next rise.
   task automatic cycle(input logic [R-1:0] v, input logic [3*R-1:0] sel,
                        input logic [N*R-1:0] a, input logic [N*R-1:0] b, input logic rr);
      int   g;
      int   k;
      int   exp_rdy;
      rsp_t o;
      @(negedge clk);
      req_valid = v; req_sel = sel; req_a = a; req_b = b; rsp_ready = rr;
      #1;
      g = -1;
      if (m_stage == 0)
         for (int i = 0; i < R; i++) begin
            k = (m_ptr + i) % R;
            if (g < 0 && v[k]) g = k;
         end
      exp_rdy  = (g >= 0) ? (1 << g) : 0;
      last_rdy = int'(req_ready);
      check("req_ready", int'(req_ready), exp_rdy);
      check("rsp_valid", int'(rsp_valid), int'(m_stage == 2));
      check("busy", int'(busy), int'(m_stage != 0));
      if (m_stage == 2) begin
         check("rsp_id", int'(rsp_id), m_exp.id);
         check("rsp_s", int'(rsp_s), m_exp.s);
         check("rsp_carry", int'(rsp_carry), m_exp.c);
         check("rsp_zero", int'(rsp_zero), m_exp.z);
         check("rsp_overflow", int'(rsp_overflow), m_exp.v);
      end
      if (rsp_valid && rsp_ready) begin
         o.id = int'(rsp_id); o.s = int'(rsp_s); o.c = int'(rsp_carry);
         o.z = int'(rsp_zero); o.v = int'(rsp_overflow);
         got.push_back(o);
      end
      case (m_stage)
         0: if (g >= 0) begin
               m_exp   = ref_alu(int'(sel[3*g +: 3]), int'(a[N*g +: N]), int'(b[N*g +: N]), g);
               m_ptr   = (g + 1) % R;
               m_stage = 1;
            end
         1: m_stage = 2;
         default: if (rr) m_stage = 0;
      endcase
   endtask

   task automatic idle(input int n);
      repeat (n) cycle('0, '0, '0, '0, 1'b1);
   endtask

   task automatic op1(input int id, input int op, input int a, input int b);
      logic [R-1:0]   v;
      logic [3*R-1:0] s;
      logic [N*R-1:0] av;
      logic [N*R-1:0] bv;
      v = '0; s = '0; av = '0; bv = '0;
      v[id] = 1'b1;
      s[3*id +: 3]  = 3'(op);
      av[N*id +: N] = N'(a);
      bv[N*id +: N] = N'(b);
      cycle(v, s, av, bv, 1'b1);
      idle(3);
   endtask

   task automatic do_reset();
      @(negedge clk);
      req_valid = '0;
      rst_n     = 1'b0;
      #1;
      check("rst_rsp_valid", int'(rsp_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_rsp_s", int'(rsp_s), 0);
      m_stage = 0;
      m_ptr   = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [N*R-1:0] av;
      logic [N*R-1:0] bv;
      logic [3*R-1:0] sv;
      int exp_ids[5];

      #1;
      check("reset_rsp_valid", int'(rsp_valid), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_req_ready", int'(req_ready), 0);
      check("reset_rsp_s", int'(rsp_s), 0);
      check("reset_rsp_id", int'(rsp_id), 0);
      check("reset_flags", int'({rsp_carry, rsp_zero, rsp_overflow}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD 7+1 from requester 2
      got.delete();
      op1(2, 0, 7, 1);
      check("add_cnt", got.size(), 1);
      if (got.size() > 0) begin
         check("add_s", got[0].s, 8);
         check("add_ov", got[0].v, 1);
         check("add_c", got[0].c, 0);
         check("add_z", got[0].z, 0);
         check("add_id", got[0].id, 2);
      end

      // SUB 3-3, CMP E<1 (signed)
      got.delete();
      op1(0, 1, 3, 3);
      op1(0, 6, 14, 1);
      check("subcmp_cnt", got.size(), 2);
      if (got.size() > 1) begin
         check("sub_s", got[0].s, 0);
         check("sub_z", got[0].z, 1);
         check("sub_c", got[0].c, 1);
         check("sub_ov", got[0].v, 0);
         check("cmp_s", got[1].s, 15);
      end

      // All requesters valid from reset: round-robin order
      do_reset();
      got.delete();
      for (int i = 0; i < 15; i++)
         cycle('1, 12'($urandom), 16'($urandom), 16'($urandom), 1'b1);
      exp_ids = '{0, 1, 2, 3, 0};
      check("rr_cnt", got.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < got.size()) check("rr_id", got[i].id, exp_ids[i]);

      // Response held while rsp_ready low
      idle(2);
      got.delete();
      av = '0; bv = '0; sv = '0;
      av[N*1 +: N] = 4'h2; bv[N*1 +: N] = 4'h3;
      cycle(4'b0010, sv, av, bv, 1'b0);
      cycle('0, '0, '0, '0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle('1, '0, '0, '0, 1'b0);
         check("hold_s", int'(rsp_s), 5);
         check("hold_busy", int'(busy), 1);
         check("hold_ready", int'(req_ready), 0);
      end
      cycle('0, '0, '0, '0, 1'b1);
      cycle('0, '0, '0, '0, 1'b1);
      check("hold_idle", int'(busy), 0);
      check("hold_cnt", got.size(), 1);

      // Reset pulse while the op is in EXEC
      cycle(4'b0100, '0, '1, '1, 1'b1);
      @(posedge clk);
      #2;
      rst_n     = 1'b0;
      req_valid = '0;
      #1;
      check("exec_rst_valid", int'(rsp_valid), 0);
      check("exec_rst_busy", int'(busy), 0);
      m_stage = 0;
      m_ptr   = 0;
      @(negedge clk);
      rst_n = 1'b1;
      got.delete();
      idle(4);
      check("exec_rst_no_rsp", got.size(), 0);
      cycle('1, '0, '0, '0, 1'b1);
      check("exec_rst_ptr", last_rdy, 1);
      idle(3);

      // Operands changed after handshake must not leak into the result
      got.delete();
      av = '0; bv = '0;
      av[N*1 +: N] = 4'h6; bv[N*1 +: N] = 4'h1;
      cycle(4'b0010, '0, av, bv, 1'b1);
      cycle('0, '0, '1, '1, 1'b1);
      idle(2);
      check("latch_cnt", got.size(), 1);
      if (got.size() > 0) check("latch_s", got[0].s, 7);

      // Random traffic
      for (int i = 0; i < 500; i++)
         cycle(4'($urandom), 12'($urandom), 16'($urandom), 16'($urandom),
               1'($urandom_range(0, 3) != 0));
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameters: N, 4, operand/result width; R, 4, number of requesters (R >= 2); IW, $clog2(R), requester-id width.
REQ-002 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req_valid  in  R  per-requester request valid.
REQ-005 SHALL have ports: req_ready  out  R  per-requester accept; at most one bit high per cycle.
REQ-006 SHALL have ports: req_sel  in  3*R  opcode per requester, slice i = [3i+2:3i].
REQ-007 SHALL have ports: req_a, req_b  in  N*R each  operands per requester, slice i = [N*i+N-1:N*i].
REQ-008 SHALL have ports: rsp_valid  out  1  result valid; rsp_ready  in  1  result consumed.
REQ-009 SHALL have ports: rsp_id  out  IW  index of requester owning the result.
REQ-010 SHALL have ports: rsp_s  out  N; rsp_carry, rsp_zero, rsp_overflow  out  1 each  registered ALU result and flags.
REQ-011 SHALL have ports: busy  out  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE, one state per cycle except RESP, which holds.
REQ-013 In IDLE, SHALL drive req_ready[g]=1 only for grantee g, chosen combinationally by round-robin from pointer ptr over req_valid; req_ready all 0 outside IDLE.
REQ-014 Round-robin: search starts at ptr, wraps R-1 -> 0; on handshake ptr <= g+1 mod R; ptr unchanged with no handshake.
REQ-015 On handshake (req_valid[g] & req_ready[g]), SHALL latch sel, a, b, g into operand registers and enter EXEC.
REQ-016 In EXEC, SHALL apply latched operands to the combinational ALU and register s, carry, zero, overflow, id into rsp_* registers; enter RESP.
REQ-017 ALU semantics per opcode: 000 ADD, 001 SUB (a + (~b+1), carry = bit N of that sum), 010 NOT a, 011 AND, 100 OR, 101 XOR, 110 CMP (signed a<b, s = all-ones if true else 0), 111 EQU (s = all-ones if a==b); logic ops force carry/zero/overflow to 0; CMP/EQU flags are those of the SUB.
REQ-018 In RESP, rsp_valid=1; rsp_* SHALL remain stable until rsp_valid & rsp_ready, then IDLE next cycle.
REQ-019 Latency: handshake in cycle t -> rsp_valid first high in cycle t+2; max throughput one op per 3 cycles.
REQ-020 req_valid deasserted before grant SHALL cause no operation; requester input changes after handshake SHALL not affect the in-flight result.
REQ-021 rsp_valid low in IDLE and EXEC; rsp_ready ignored when rsp_valid low.

Reset
REQ-022 rst_n low SHALL asynchronously force: state IDLE, ptr 0, rsp_valid 0, rsp_s 0, rsp_carry/zero/overflow 0, rsp_id 0, busy 0, operand registers 0.
REQ-023 Reset asserted mid-EXEC or mid-RESP SHALL discard the in-flight op; no rsp_valid pulse after release.
REQ-024 First cycle after rst_n rises SHALL be IDLE and may grant.

Structure
REQ-025 Opcode constants (ADD..EQU) and FSM state encoding SHALL live in shared package alu_pkg.
REQ-026 SHALL instantiate the team's combinational alu (parameter N) as its single sub-module; round-robin and FSM in alu_sched.

Verification
REQ-027 ADD a=4'h7 b=4'h1 from requester 2 -> rsp_s=4'h8, overflow=1, carry=0, zero=0, rsp_id=2, rsp_valid at t+2.
REQ-028 SUB a=4'h3 b=4'h3 -> rsp_s=0, zero=1, carry=1, overflow=0; CMP a=4'hE b=4'h1 -> rsp_s=4'hF.
REQ-029 All four req_valid held high from reset, rsp_ready=1 -> grant order 0,1,2,3,0, each rsp_id matching.
REQ-030 rsp_ready low 5 cycles in RESP -> rsp_* stable, req_ready all 0, busy=1; one cycle after rsp_ready high, IDLE.
REQ-031 rst_n pulsed low during EXEC -> rsp_valid 0 immediately, ptr 0, no response delivered afterwards.
REQ-032 Requester 1 changes req_a/req_b the cycle after its handshake -> result reflects originally latched operands.
